// File: rtl/wb_regfile.sv
// MIPS write-back stage and architectural register file.
// Selects the write-back value, commits it to 31 GPRs plus HI/LO, and serves two ID read ports with write-through.
module wb_regfile (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] PCPlus4,
  input  logic [31:0] data,
  input  logic [31:0] ALURes,
  input  logic [31:0] Wlo,
  input  logic [4:0]  WAddr,
  input  logic [1:0]  whatToReg,
  input  logic        regWrite,
  input  logic [1:0]  move,
  input  logic [4:0]  RAddr1,
  input  logic [4:0]  RAddr2,
  output logic [31:0] RData1,
  output logic [31:0] RData2,
  output logic [31:0] WBData,
  output logic [31:0] HIo,
  output logic [31:0] LOo
);

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_MEM = 2'b01,
    SEL_PC  = 2'b10,
    SEL_LO  = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    MV_NONE = 2'b00,
    MV_LO   = 2'b01,
    MV_HILO = 2'b10,
    MV_HI   = 2'b11
  } move_e;

  // Register 0 has no storage; it is synthesised as a constant zero on the read path.
  logic [31:0] regs_q [1:31];
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        gpr_we;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    WBData = ALURes;
    case (wb_sel_e'(whatToReg))
      SEL_ALU: WBData = ALURes;
      SEL_MEM: WBData = data;
      SEL_PC:  WBData = PCPlus4;
      SEL_LO:  WBData = lo_q;
      default: WBData = ALURes;
    endcase
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (move_e'(move))
      MV_NONE: ;
      MV_LO:   lo_d = Wlo;
      MV_HILO: begin
        hi_d = ALURes;
        lo_d = Wlo;
      end
      MV_HI:   hi_d = ALURes;
      default: ;
    endcase
  end

  // Same qualifier gates both the commit and the bypass, so reset suppresses both.
  assign gpr_we = RSTn && regWrite && (WAddr != 5'd0);

  assign RData1 = (gpr_we && (RAddr1 == WAddr)) ? WBData :
                  (RAddr1 == 5'd0)              ? 32'd0  : regs_q[RAddr1];
  assign RData2 = (gpr_we && (RAddr2 == WAddr)) ? WBData :
                  (RAddr2 == 5'd0)              ? 32'd0  : regs_q[RAddr2];

  assign HIo = hi_q;
  assign LOo = lo_q;

  // NOTE: sequential state uses non-blocking assignments only; the array is
  // explicitly cleared on reset because software relies on zeroed GPRs.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (gpr_we) regs_q[WAddr] <= WBData;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed and randomized self-checking bench for wb_regfile.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
module tb_wb_regfile;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] PCPlus4, data, ALURes, Wlo;
  logic [4:0]  WAddr, RAddr1, RAddr2;
  logic [1:0]  whatToReg, move;
  logic        regWrite;
  logic [31:0] RData1, RData2, WBData, HIo, LOo;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  wb_regfile dut (
    .CLK(CLK), .RSTn(RSTn), .PCPlus4(PCPlus4), .data(data), .ALURes(ALURes),
    .Wlo(Wlo), .WAddr(WAddr), .whatToReg(whatToReg), .regWrite(regWrite),
    .move(move), .RAddr1(RAddr1), .RAddr2(RAddr2), .RData1(RData1),
    .RData2(RData2), .WBData(WBData), .HIo(HIo), .LOo(LOo)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RSTn = 1'b1; regWrite = 1'b0; move = 2'b00; whatToReg = 2'b00;
    WAddr = 5'd0; PCPlus4 = 32'd0; data = 32'd0; ALURes = 32'd0; Wlo = 32'd0;
  endtask

  task automatic test_reset();
    idle();
    RSTn = 1'b0; RAddr1 = 5'd5; RAddr2 = 5'd0;
    tick();
    idle();
    regWrite = 1'b1; WAddr = 5'd5; ALURes = 32'h1234_5678; Wlo = 32'h0000_0777; move = 2'b10;
    tick();
    RSTn = 1'b0; regWrite = 1'b1; WAddr = 5'd5; ALURes = 32'hDEAD_BEEF; move = 2'b10;
    #4;
    checks++;
    if (WBData !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL reset_wbdata got %h exp %h", WBData, 32'hDEAD_BEEF);
    end
    checks++;
    if (RData1 !== 32'h1234_5678) begin
      errors++; $display("FAIL reset_no_bypass got %h exp %h", RData1, 32'h1234_5678);
    end
    tick();
    idle(); RAddr1 = 5'd5;
    #4;
    checks++;
    if (RData1 !== 32'd0) begin errors++; $display("FAIL reset_reg5 got %h exp 0", RData1); end
    checks++;
    if (HIo !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", HIo); end
    checks++;
    if (LOo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", LOo); end
    tick();
  endtask

  task automatic test_source_select();
    logic [31:0] exp_val [4];
    exp_val[0] = 32'h11; exp_val[1] = 32'h22; exp_val[2] = 32'h33; exp_val[3] = 32'h44;
    idle(); move = 2'b01; Wlo = 32'h44;
    tick();
    for (int s = 0; s < 4; s++) begin
      idle();
      regWrite = 1'b1; WAddr = 5'd3; whatToReg = 2'(s);
      ALURes = 32'h11; data = 32'h22; PCPlus4 = 32'h33; Wlo = 32'h55;
      #4;
      checks++;
      if (WBData !== exp_val[s]) begin
        errors++; $display("FAIL srcsel_wbdata sel=%0d got %h exp %h", s, WBData, exp_val[s]);
      end
      tick();
      idle(); RAddr1 = 5'd3;
      #4;
      checks++;
      if (RData1 !== exp_val[s]) begin
        errors++; $display("FAIL srcsel_reg3 sel=%0d got %h exp %h", s, RData1, exp_val[s]);
      end
      tick();
    end
  endtask

  task automatic test_reg_zero();
    for (int c = 0; c < 3; c++) begin
      idle();
      regWrite = 1'b1; WAddr = 5'd0; ALURes = 32'hFFFF_FFFF; RAddr1 = 5'd0; RAddr2 = 5'd0;
      #4;
      checks++;
      if (RData1 !== 32'd0) begin errors++; $display("FAIL reg0_port1 cyc=%0d got %h exp 0", c, RData1); end
      checks++;
      if (RData2 !== 32'd0) begin errors++; $display("FAIL reg0_port2 cyc=%0d got %h exp 0", c, RData2); end
      tick();
    end
  endtask

  task automatic test_bypass();
    idle(); regWrite = 1'b1; WAddr = 5'd7; ALURes = 32'h10;
    tick();
    idle(); regWrite = 1'b1; WAddr = 5'd7; ALURes = 32'h99; RAddr1 = 5'd7; RAddr2 = 5'd7;
    #4;
    checks++;
    if (RData1 !== 32'h99) begin errors++; $display("FAIL bypass_p1 got %h exp 99", RData1); end
    checks++;
    if (RData2 !== 32'h99) begin errors++; $display("FAIL bypass_p2 got %h exp 99", RData2); end
    tick();
    idle();
    #4;
    checks++;
    if (RData1 !== 32'h99) begin errors++; $display("FAIL bypass_commit got %h exp 99", RData1); end
    regWrite = 1'b1; WAddr = 5'd7; ALURes = 32'h10;
    tick();
    idle(); RSTn = 1'b0; regWrite = 1'b1; WAddr = 5'd7; ALURes = 32'h99;
    #4;
    checks++;
    if (RData1 !== 32'h10) begin errors++; $display("FAIL bypass_rst_p1 got %h exp 10", RData1); end
    checks++;
    if (RData2 !== 32'h10) begin errors++; $display("FAIL bypass_rst_p2 got %h exp 10", RData2); end
    tick();
    idle();
    #4;
    checks++;
    if (RData1 !== 32'd0) begin errors++; $display("FAIL bypass_rst_after_p1 got %h exp 0", RData1); end
    checks++;
    if (RData2 !== 32'd0) begin errors++; $display("FAIL bypass_rst_after_p2 got %h exp 0", RData2); end
    tick();
  endtask

  task automatic test_hilo();
    idle(); move = 2'b10; ALURes = 32'hA; Wlo = 32'hB;
    #4;
    checks++;
    if (HIo !== 32'd0 || LOo !== 32'd0) begin
      errors++; $display("FAIL hilo_no_bypass got hi=%h lo=%h exp 0/0", HIo, LOo);
    end
    tick();
    idle(); move = 2'b01; Wlo = 32'hC; whatToReg = 2'b11; regWrite = 1'b1; WAddr = 5'd4;
    #4;
    checks++;
    if (HIo !== 32'hA || LOo !== 32'hB) begin
      errors++; $display("FAIL hilo_pair got hi=%h lo=%h exp a/b", HIo, LOo);
    end
    checks++;
    if (WBData !== 32'hB) begin errors++; $display("FAIL hilo_old_lo got %h exp b", WBData); end
    tick();
    idle(); RAddr1 = 5'd4; move = 2'b11; ALURes = 32'hD;
    #4;
    checks++;
    if (RData1 !== 32'hB) begin errors++; $display("FAIL hilo_reg4 got %h exp b", RData1); end
    checks++;
    if (HIo !== 32'hA || LOo !== 32'hC) begin
      errors++; $display("FAIL hilo_lo_only got hi=%h lo=%h exp a/c", HIo, LOo);
    end
    tick();
    idle();
    #4;
    checks++;
    if (HIo !== 32'hD || LOo !== 32'hC) begin
      errors++; $display("FAIL hilo_hi_only got hi=%h lo=%h exp d/c", HIo, LOo);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 3; k++) begin
      idle(); regWrite = 1'b1; WAddr = 5'd9; ALURes = 32'(k * 32'h101); RAddr2 = 5'd9;
      #4;
      checks++;
      if (RData2 !== 32'(k * 32'h101)) begin
        errors++; $display("FAIL b2b_bypass k=%0d got %h exp %h", k, RData2, 32'(k * 32'h101));
      end
      tick();
    end
    idle(); RAddr2 = 5'd9;
    #4;
    checks++;
    if (RData2 !== 32'h303) begin errors++; $display("FAIL b2b_last got %h exp 303", RData2); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] m [32];
    logic [31:0] m_hi, m_lo, e_wb, e_r1, e_r2;
    idle(); RSTn = 1'b0;
    tick();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      RSTn      = ($urandom_range(0, 63) != 0);
      regWrite  = ($urandom_range(0, 3) != 0);
      move      = 2'($urandom_range(0, 3));
      whatToReg = 2'($urandom_range(0, 3));
      WAddr     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      RAddr1    = ($urandom_range(0, 3) == 0) ? WAddr : 5'($urandom_range(0, 31));
      RAddr2    = ($urandom_range(0, 3) == 0) ? WAddr : 5'($urandom_range(0, 31));
      PCPlus4 = $urandom; data = $urandom; ALURes = $urandom; Wlo = $urandom;
      case (whatToReg)
        2'b00:   e_wb = ALURes;
        2'b01:   e_wb = data;
        2'b10:   e_wb = PCPlus4;
        default: e_wb = m_lo;
      endcase
      e_r1 = (RSTn && regWrite && WAddr != 0 && RAddr1 == WAddr) ? e_wb : m[RAddr1];
      e_r2 = (RSTn && regWrite && WAddr != 0 && RAddr2 == WAddr) ? e_wb : m[RAddr2];
      #4;
      checks++;
      if (WBData !== e_wb) begin errors++; $display("FAIL rnd_wb cyc=%0d got %h exp %h", cyc, WBData, e_wb); end
      checks++;
      if (RData1 !== e_r1) begin errors++; $display("FAIL rnd_r1 cyc=%0d got %h exp %h", cyc, RData1, e_r1); end
      checks++;
      if (RData2 !== e_r2) begin errors++; $display("FAIL rnd_r2 cyc=%0d got %h exp %h", cyc, RData2, e_r2); end
      checks++;
      if (HIo !== m_hi || LOo !== m_lo) begin
        errors++; $display("FAIL rnd_hilo cyc=%0d got %h/%h exp %h/%h", cyc, HIo, LOo, m_hi, m_lo);
      end
      if (!RSTn) begin
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
      end else begin
        if (regWrite && WAddr != 0) m[WAddr] = e_wb;
        if (move == 2'b10 || move == 2'b11) m_hi = ALURes;
        if (move == 2'b01 || move == 2'b10) m_lo = Wlo;
      end
      tick();
    end
  endtask

  initial begin
    RAddr1 = 5'd0; RAddr2 = 5'd0;
    idle();
    #1;
    test_reset();
    test_source_select();
    test_reg_zero();
    test_bypass();
    test_hilo();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the pipelined MIPS core. Consumes the outputs of the MEM/WB pipeline register, selects the write-back value, and commits it to a 32×32 general-purpose register file plus the HI/LO pair. Serves the ID stage's two combinational read ports with same-cycle write-through bypass, and exports HI/LO for EX-stage use.

## Interface
Parameters:
- none; widths are fixed at 32-bit data and 5-bit register address.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- PCPlus4  in  32  return address from MEM/WB.
- data  in  32  load data from MEM/WB.
- ALURes  in  32  ALU result from MEM/WB; also the HI source.
- Wlo  in  32  LO source from MEM/WB.
- WAddr  in  5  destination register.
- whatToReg  in  2  write-back source select.
- regWrite  in  1  GPR write enable.
- move  in  2  HI/LO write control.
- RAddr1, RAddr2  in  5 each  ID-stage read addresses.
- RData1, RData2  out  32 each  ID-stage read data, combinational.
- WBData  out  32  selected write-back value, combinational, for forwarding.
- HIo, LOo  out  32 each  current HI/LO register contents.

## Operation
- Source select, combinational: whatToReg 00 → ALURes; 01 → data; 10 → PCPlus4; 11 → LO register (current, pre-update value).
- GPR write: at a rising CLK edge with RSTn=1, regWrite=1 and WAddr≠0, regs[WAddr] ← WBData.
- Register 0 is hard-wired to 0. Writes to it are discarded. Reads of it return 0, and bypass never applies to it.
- HI/LO write, at a rising CLK edge with RSTn=1:
  - move 00: no change.
  - move 01: LO ← Wlo.
  - move 10: HI ← ALURes and LO ← Wlo (multiply/divide result pair).
  - move 11: HI ← ALURes.
- HI/LO writes are independent of regWrite.
- whatToReg=11 together with a move writing LO in the same cycle: WBData uses the old LO, and the new LO is committed at the edge.
- Read port n, combinational:
  - if RSTn=1, regWrite=1, WAddr≠0 and RAddrn=WAddr, RDatan = WBData (write-through);
  - else if RAddrn=0, RDatan = 0;
  - else RDatan = regs[RAddrn].
- Both ports are independent. Both may bypass in the same cycle.
- HIo and LOo show the register contents directly. They do not bypass pending HI/LO writes.
- Reset: a rising edge with RSTn=0 clears all 31 GPRs, HI and LO to 0. All writes presented in that cycle are dropped. While RSTn=0, bypass is suppressed.
- Reset values of outputs after the reset edge: RData1/2 = 0, HIo = 0, LOo = 0. WBData follows its inputs combinationally.

## Timing
- Write latency: the value is in the array at the edge, visible from the array the cycle after. It is visible through the bypass in the same cycle it is presented.
- Read latency: 0 cycles (combinational from RAddr and array state).
- HI/LO: the new value appears on HIo/LOo one cycle after the edge. There is no same-cycle bypass.
- Back-to-back writes to the same WAddr on consecutive cycles: last write wins. Each intermediate value is bypass-visible in its own cycle.
- No stall or handshake. A write occurs every cycle that regWrite=1. Upstream bubbles must arrive as regWrite=0 and move=00.
- Reset asserted mid-stream: the instruction in WB on the reset edge is not committed.

## Test plan
- Reset: hold RSTn=0 one edge with regWrite=1, WAddr=5, ALURes=0xDEAD_BEEF, move=10 → after the edge, RData for addr 5 = 0, HIo = 0, LOo = 0.
- Source select: for each whatToReg in turn, write to WAddr=3 with ALURes=0x11, data=0x22, PCPlus4=0x33 (LO preloaded to 0x44) → reg3 reads 0x11, then 0x22, then 0x33, then 0x44 on the following cycles.
- Register 0: regWrite=1, WAddr=0, ALURes=0xFFFF_FFFF, RAddr1=0 → RData1 = 0 in the same cycle and in every later cycle.
- Bypass: reg7 holds 0x10. Present a write of 0x99 to reg7 with RAddr1=RAddr2=7 → both ports read 0x99 in that same cycle, and 0x99 after the edge. Repeat with RSTn=0 → both read 0x10 in the cycle, then 0 after the edge.
- HI/LO:
  - move=10, ALURes=0xA, Wlo=0xB → HIo=0xA, LOo=0xB next cycle.
  - Then move=01, Wlo=0xC with whatToReg=11, regWrite=1, WAddr=4 → reg4 = 0xB, LOo = 0xC, HIo = 0xA.
  - Then move=11, ALURes=0xD → HIo=0xD, LOo=0xC.
- Random regression: 10k cycles of random inputs checked against a reference model of the array, HI and LO, including repeated WAddr and RAddr=WAddr collisions.
